// File: rtl/i2s_rx_fifo.sv
// I2S / left-justified stereo receiver. It deserialises the slots, pairs each left
// sample with the right sample that follows it, and queues the frames in a small FIFO.
module i2s_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             ws,
    input  logic             sd,
    input  logic             lj,
    output logic [WIDTH-1:0] data_left,
    output logic [WIDTH-1:0] data_right,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             short_slot
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    logic             ws_prev;
    logic             hist_valid;
    logic             start_next;
    logic             start_ch;
    logic             started;
    logic             cur_ch;
    logic             cur_counted;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             left_pend;
    logic [WIDTH-1:0] left_val;
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic [WIDTH-1:0] mem_left  [DEPTH];
    logic [WIDTH-1:0] mem_right [DEPTH];

    logic             trans;
    logic             slot_start;
    logic             new_ch;
    logic             commit;
    logic             slot_short;
    logic             push_req;
    logic             empty;
    logic             full;
    logic             pop;
    logic             do_push;
    logic [WIDTH-1:0] sr_start;
    logic [WIDTH-1:0] sr_next;

    // In I2S mode the slot begins one sck after the ws change, so the start is delayed via start_next.
    always_comb begin
        trans      = hist_valid && (ws != ws_prev);
        slot_start = lj ? trans : start_next;
        new_ch     = lj ? ws : start_ch;
        commit     = slot_start && cur_counted;
        slot_short = cnt < WIDTH_C;
        push_req   = commit && cur_ch && left_pend;
        empty      = (wptr == rptr);
        full       = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
        pop        = !empty && ready;
        do_push    = push_req && (!full || pop);
        sr_start   = '0;
        sr_start[WIDTH-1] = sd;
        sr_next    = sr;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(WIDTH - 1 - i)) begin
                sr_next[i] = sd;
            end
        end
    end

    // The slot opened at the first boundary after reset is never committed, so only complete slots count.
    always_ff @(posedge sck) begin
        if (rst) begin
            ws_prev     <= 1'b0;
            hist_valid  <= 1'b0;
            start_next  <= 1'b0;
            start_ch    <= 1'b0;
            started     <= 1'b0;
            cur_ch      <= 1'b0;
            cur_counted <= 1'b0;
            sr          <= '0;
            cnt         <= '0;
            left_pend   <= 1'b0;
            left_val    <= '0;
            wptr        <= '0;
            rptr        <= '0;
            overflow    <= 1'b0;
            short_slot  <= 1'b0;
        end else begin
            ws_prev    <= ws;
            hist_valid <= 1'b1;
            start_next <= trans;
            start_ch   <= ws;
            if (slot_start) begin
                sr          <= sr_start;
                cnt         <= CW'(1);
                cur_ch      <= new_ch;
                cur_counted <= started;
                started     <= 1'b1;
            end else if (started && slot_short) begin
                sr  <= sr_next;
                cnt <= cnt + CW'(1);
            end
            if (commit) begin
                if (slot_short) begin
                    short_slot <= 1'b1;
                end
                if (!cur_ch) begin
                    left_pend <= 1'b1;
                    left_val  <= sr;
                end else begin
                    left_pend <= 1'b0;
                end
            end
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sck) begin
        if (!rst && do_push) begin
            mem_left[wptr[PW-1:0]]  <= left_val;
            mem_right[wptr[PW-1:0]] <= sr;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    always_comb begin
        valid      = !empty;
        data_left  = valid ? mem_left[rptr[PW-1:0]]  : '0;
        data_right = valid ? mem_right[rptr[PW-1:0]] : '0;
    end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench for i2s_rx_fifo: a table of single-frame streams in both formats,
// plus hand-written sequences for latency, overflow, full push/pop and mid-slot reset.
module tb_i2s_rx_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             sck = 1'b0;
    logic             rst;
    logic             ws;
    logic             sd;
    logic             lj;
    logic             ready;
    logic [WIDTH-1:0] data_left;
    logic [WIDTH-1:0] data_right;
    logic             valid;
    logic             overflow;
    logic             short_slot;

    int tests = 0;
    int fails = 0;
    bit ws_q[$];
    bit sd_q[$];

    typedef struct {
        bit          lj;
        bit          shift;
        int          nbits;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic [31:0] exp_short;
    } vec_t;

    vec_t vecs[7];

    i2s_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sck        (sck),
        .rst        (rst),
        .ws         (ws),
        .sd         (sd),
        .lj         (lj),
        .data_left  (data_left),
        .data_right (data_right),
        .valid      (valid),
        .ready      (ready),
        .overflow   (overflow),
        .short_slot (short_slot)
    );

    always #5 sck = ~sck;

    task automatic step();
        @(posedge sck);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic emit(input bit ch, input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            ws_q.push_back(ch);
            sd_q.push_back(value[i]);
        end
    endtask

    // Idle bits, then a short right slot that only serves as the alignment boundary.
    task automatic new_stream();
        ws_q.delete();
        sd_q.delete();
        emit(1'b0, 32'h0, 3);
        emit(1'b1, 32'h0, 4);
    endtask

    // shift=1 moves ws one sck earlier than the data, giving a proper I2S stream.
    task automatic apply_stimulus(input bit shift, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            int nk;
            nk = (shift && (k + 1 < ws_q.size())) ? k + 1 : k;
            ws = ws_q[nk];
            sd = sd_q[k];
            step();
        end
    endtask

    task automatic do_reset(input bit fmt);
        rst   = 1'b1;
        lj    = fmt;
        ws    = 1'b0;
        sd    = 1'b0;
        ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [31:0] exp_l, input logic [31:0] exp_r);
        check_output({name, "_valid"}, 32'(valid), 32'h1);
        check_output({name, "_left"}, 32'(data_left), exp_l);
        check_output({name, "_right"}, 32'(data_right), exp_r);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        int len;
        rst   = 1'b1;
        ws    = 1'b0;
        sd    = 1'b0;
        lj    = 1'b0;
        ready = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 16, 32'hA5C3,   32'h1234,   32'hA5C3, 32'h1234, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 16, 32'hA5C3,   32'h1234,   32'hA5C3, 32'h1234, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 16, 32'hA5C3,   32'h1234,   32'h4B86, 32'h2468, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 24, 32'hA5C3FF, 32'h1234EE, 32'hA5C3, 32'h1234, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 12, 32'hABC,    32'h123,    32'hABC0, 32'h1230, 32'h1};
        vecs[5] = '{1'b0, 1'b1, 24, 32'hA5C3FF, 32'h1234EE, 32'hA5C3, 32'h1234, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 12, 32'hABC,    32'h123,    32'hABC0, 32'h1230, 32'h1};

        do_reset(1'b0);
        check_output("reset_valid", 32'(valid), 32'h0);
        check_output("reset_overflow", 32'(overflow), 32'h0);
        check_output("reset_short", 32'(short_slot), 32'h0);
        check_output("reset_left", 32'(data_left), 32'h0);
        check_output("reset_right", 32'(data_right), 32'h0);

        foreach (vecs[i]) begin
            do_reset(vecs[i].lj);
            new_stream();
            emit(1'b0, vecs[i].l, vecs[i].nbits);
            emit(1'b1, vecs[i].r, vecs[i].nbits);
            emit(1'b0, 32'h0, 2);
            apply_stimulus(vecs[i].shift, 0, ws_q.size() - 1);
            check_output($sformatf("vec%0d_overflow", i), 32'(overflow), 32'h0);
            check_output($sformatf("vec%0d_short", i), 32'(short_slot), vecs[i].exp_short);
            pop_expect($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
            check_output($sformatf("vec%0d_empty", i), 32'(valid), 32'h0);
        end

        // Valid must appear right after the edge that commits the right slot, not before.
        do_reset(1'b0);
        new_stream();
        emit(1'b0, 32'hA5C3, 16);
        emit(1'b1, 32'h1234, 16);
        emit(1'b0, 32'h0, 2);
        len = ws_q.size();
        apply_stimulus(1'b1, 0, len - 3);
        check_output("latency_before", 32'(valid), 32'h0);
        apply_stimulus(1'b1, len - 2, len - 2);
        check_output("latency_after", 32'(valid), 32'h1);
        apply_stimulus(1'b1, len - 1, len - 1);
        pop_expect("latency", 32'hA5C3, 32'h1234);

        do_reset(1'b1);
        new_stream();
        for (int f = 1; f <= 5; f++) begin
            emit(1'b0, 32'h1000 + 32'(f), 16);
            emit(1'b1, 32'h2000 + 32'(f), 16);
        end
        emit(1'b0, 32'h0, 2);
        len = ws_q.size();
        apply_stimulus(1'b0, 0, len - 1);
        check_output("ovf_flag", 32'(overflow), 32'h1);
        for (int f = 1; f <= 4; f++) begin
            pop_expect($sformatf("ovf_pop%0d", f), 32'h1000 + 32'(f), 32'h2000 + 32'(f));
        end
        check_output("ovf_drained", 32'(valid), 32'h0);
        check_output("ovf_sticky", 32'(overflow), 32'h1);

        // Popping on the fifth push edge makes room, so nothing is dropped.
        do_reset(1'b1);
        apply_stimulus(1'b0, 0, len - 3);
        check_output("full_pop_pre_valid", 32'(valid), 32'h1);
        check_output("full_pop_pre_ovf", 32'(overflow), 32'h0);
        ready = 1'b1;
        apply_stimulus(1'b0, len - 2, len - 2);
        ready = 1'b0;
        apply_stimulus(1'b0, len - 1, len - 1);
        check_output("full_pop_ovf", 32'(overflow), 32'h0);
        for (int f = 2; f <= 5; f++) begin
            pop_expect($sformatf("full_pop%0d", f), 32'h1000 + 32'(f), 32'h2000 + 32'(f));
        end
        check_output("full_pop_drained", 32'(valid), 32'h0);

        do_reset(1'b1);
        new_stream();
        emit(1'b0, 32'hABC, 12);
        emit(1'b1, 32'h123, 12);
        emit(1'b0, 32'hFF, 8);
        apply_stimulus(1'b0, 0, ws_q.size() - 1);
        check_output("midrst_pre_valid", 32'(valid), 32'h1);
        check_output("midrst_pre_short", 32'(short_slot), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midrst_valid", 32'(valid), 32'h0);
        check_output("midrst_short", 32'(short_slot), 32'h0);
        check_output("midrst_overflow", 32'(overflow), 32'h0);
        check_output("midrst_left", 32'(data_left), 32'h0);
        new_stream();
        emit(1'b0, 32'h1357, 16);
        emit(1'b1, 32'h2468, 16);
        emit(1'b0, 32'h0, 2);
        apply_stimulus(1'b0, 0, ws_q.size() - 1);
        pop_expect("midrst_frame", 32'h1357, 32'h2468);
        check_output("midrst_drained", 32'(valid), 32'h0);
        check_output("midrst_post_short", 32'(short_slot), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
